// File: rtl/fdiv_ratio_meter.sv
// ---------------------------------------------------------------------------
// fdiv_ratio_meter
//
// Measures the period of a divided clock (sig_in) in cycles of clk_in. This
// recovers the divide ratio. It also reports how many of those cycles sig_in
// was high. sig_in may be asynchronous to clk_in, so it is first passed
// through a SYNC_STAGES-flop synchronizer and then one history flop.
// A rising edge is "synchronized high and history low".
//
// Parameters
//   SYNC_STAGES : synchronizer depth on sig_in (2 or 3)
//
// Ports
//   clk_in   : sole clock, rising-edge active
//   rst      : asynchronous, active-low reset
//   sig_in   : divided clock under measurement
//   n_meas   : last measured period, in clk_in cycles (2..255)
//   high_cnt : clk_in cycles sig_in was high within that period
//   valid    : one-cycle pulse; n_meas/high_cnt update in the same cycle
//   locked   : the last two consecutive measurements were identical
//   timeout  : no rising edge seen for 255 cycles while measuring
// ---------------------------------------------------------------------------
module fdiv_ratio_meter #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       sig_in,
  output logic [7:0] n_meas,
  output logic [7:0] high_cnt,
  output logic       valid,
  output logic       locked,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    STALL   = 2'd2
  } state_t;

  state_t                 state_q,    state_d;
  logic [SYNC_STAGES-1:0] sync_q,     sync_d;
  logic                   hist_q,     hist_d;
  logic [7:0]             period_q,   period_d;
  logic [7:0]             high_q,     high_d;
  logic [7:0]             n_meas_q,   n_meas_d;
  logic [7:0]             high_cnt_q, high_cnt_d;
  logic                   valid_q,    valid_d;
  logic                   locked_q,   locked_d;
  logic                   timeout_q,  timeout_d;
  // Set once a measurement exists that a new one may be compared against.
  // It is cleared on reset and on STALL entry. This keeps the first
  // measurement after either event from ever setting locked.
  logic                   have_prev_q, have_prev_d;

  logic sync_hi;
  logic rise;

  // Synchronizer and edge detection
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], sig_in};
    sync_hi = sync_q[SYNC_STAGES-1];
    hist_d  = sync_hi;
    rise    = sync_hi & ~hist_q;
  end

  // Measurement FSM: next state and counters
  always_comb begin
    state_d     = state_q;
    period_d    = period_q;
    high_d      = high_q;
    n_meas_d    = n_meas_q;
    high_cnt_d  = high_cnt_q;
    valid_d     = 1'b0;
    locked_d    = locked_q;
    timeout_d   = timeout_q;
    have_prev_d = have_prev_q;

    case (state_q)
      IDLE: begin
        // The first edge only arms the meter; no period is known yet.
        if (rise) begin
          state_d  = MEASURE;
          period_d = 8'd1;
          high_d   = 8'd1;
        end
      end

      MEASURE: begin
        if (rise) begin
          // An edge takes priority over the 255 limit, so a period of
          // exactly 255 is still reported.
          n_meas_d    = period_q;
          high_cnt_d  = high_q;
          valid_d     = 1'b1;
          locked_d    = have_prev_q && (period_q == n_meas_q) &&
                        (high_q == high_cnt_q);
          have_prev_d = 1'b1;
          period_d    = 8'd1;
          high_d      = 8'd1;
        end else if (period_q == 8'd255) begin
          // Saturate rather than wrap: stop measuring and flag timeout.
          state_d     = STALL;
          timeout_d   = 1'b1;
          locked_d    = 1'b0;
          have_prev_d = 1'b0;
        end else begin
          period_d = period_q + 8'd1;
          if (sync_hi) begin
            high_d = high_q + 8'd1;
          end
        end
      end

      STALL: begin
        // Results are held. The next edge restarts counting without
        // reporting, because the stalled interval is not a valid period.
        if (rise) begin
          state_d   = MEASURE;
          timeout_d = 1'b0;
          period_d  = 8'd1;
          high_d    = 8'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      sync_q      <= '0;
      hist_q      <= 1'b0;
      period_q    <= 8'd0;
      high_q      <= 8'd0;
      n_meas_q    <= 8'd0;
      high_cnt_q  <= 8'd0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      timeout_q   <= 1'b0;
      have_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      hist_q      <= hist_d;
      period_q    <= period_d;
      high_q      <= high_d;
      n_meas_q    <= n_meas_d;
      high_cnt_q  <= high_cnt_d;
      valid_q     <= valid_d;
      locked_q    <= locked_d;
      timeout_q   <= timeout_d;
      have_prev_q <= have_prev_d;
    end
  end

  assign n_meas   = n_meas_q;
  assign high_cnt = high_cnt_q;
  assign valid    = valid_q;
  assign locked   = locked_q;
  assign timeout  = timeout_q;

endmodule

// File: doc/fdiv_ratio_meter.md
FDIV_RATIO_METER -- requirements
Module: fdiv_ratio_meter

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchronizer flops on sig_in; legal values 2..3.
REQ-002 clk_in  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low; rst=0 forces reset state immediately.
REQ-004 sig_in  input  1  divided clock to be measured; may be asynchronous to clk_in.
REQ-005 n_meas  output  8  last measured period of sig_in, in clk_in cycles (recovered divide ratio).
REQ-006 high_cnt  output  8  clk_in cycles sig_in was high within the last measured period.
REQ-007 valid  output  1  one-cycle pulse; n_meas/high_cnt updated in that same cycle.
REQ-008 locked  output  1  level; the last two consecutive measurements were equal.
REQ-009 timeout  output  1  level; no sig_in rising edge within 255 cycles.

Function
REQ-010 sig_in SHALL pass through a SYNC_STAGES-flop synchronizer plus one history flop; rising edge = synchronized high AND history low.
REQ-011 FSM states SHALL be IDLE, MEASURE and STALL; reset state is IDLE.
REQ-012 IDLE: on a detected rising edge go to MEASURE and load period counter to 1 and high counter to 1; no measurement is produced.
REQ-013 MEASURE, no edge: period counter SHALL increment by 1; high counter SHALL increment when the synchronized sig_in is high.
REQ-014 MEASURE, edge: n_meas <= period counter, high_cnt <= high counter, valid=1 for that cycle, counters reload to 1; remain in MEASURE.
REQ-015 Measured period SHALL equal the number of clk_in cycles between consecutive detected edges; minimum 2, maximum 255.
REQ-016 With SYNC_STAGES=2 and sig_in synchronous to clk_in, valid SHALL rise on the 3rd clk_in rising edge that samples sig_in high.
REQ-017 An edge arriving while period counter = 255 SHALL produce a valid measurement of 255.
REQ-018 Period counter = 255 with no edge: go to STALL next cycle, set timeout=1, clear locked, suppress valid; counters never wrap.
REQ-019 STALL: n_meas/high_cnt SHALL hold; on a detected edge clear timeout, reload counters to 1, go to MEASURE, produce no measurement.
REQ-020 locked SHALL set in the valid cycle where the new n_meas equals the previous n_meas AND the new high_cnt equals the previous high_cnt.
REQ-021 locked SHALL clear in a valid cycle where either value differs, and on entry to STALL.
REQ-022 The first measurement after reset or after STALL SHALL never set locked.
REQ-023 n_meas and high_cnt SHALL hold their values between valid pulses.

Reset
REQ-024 rst=0 SHALL asynchronously clear synchronizer and history flops, counters, n_meas=0, high_cnt=0, valid=0, locked=0, timeout=0, and FSM=IDLE.
REQ-025 Reset asserted mid-measurement SHALL discard the partial count; after release the first detected edge only arms the meter (REQ-012).
REQ-026 Outputs SHALL remain at reset values until the first complete period after rst release.

Verification
REQ-027 Square wave period 6 (3 high/3 low), sync to clk_in -> valid every 6 cycles, n_meas=6, high_cnt=3; locked=1 from the 2nd valid.
REQ-028 Period 6 switched to period 11 (5 high/6 low) -> locked=0 at the first differing valid; n_meas=11, high_cnt=5 thereafter; locked=1 again after two equal periods of 11.
REQ-029 sig_in held low after locking at period 6 -> timeout=1 and locked=0 exactly 255 cycles after the last counter reload; valid stays 0; the next edge clears timeout with no valid; the following edge gives a valid.
REQ-030 Period 2 (1 high/1 low) -> n_meas=2, high_cnt=1 every 2 cycles; period 255 -> n_meas=255 with timeout=0.
REQ-031 rst pulsed low mid-period during period-11 operation -> all outputs 0 immediately; after release no valid until two edges are seen; the first valid reports n_meas=11 with locked=0.
REQ-032 sig_in asynchronous to clk_in, nominal ratio 11 -> every n_meas is in 10..12 and no valid is emitted outside MEASURE.
